// File: rtl/snn_pkg.sv
// snn_pkg: shared defaults and counter-width helpers for the SNN switch front end
package snn_pkg;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int DEFAULT_SPIKE_PERIOD    = 5;
    localparam int DEFAULT_DB_CNT_W        = $clog2(DEFAULT_DEBOUNCE_CYCLES + 1);
    localparam int DEFAULT_PHASE_W         = $clog2(DEFAULT_SPIKE_PERIOD);

    function automatic int db_cnt_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

    function automatic int phase_w(input int period);
        return $clog2(period);
    endfunction
endpackage

// File: rtl/spike_encoder_channel.sv
// spike_encoder_channel: sync, debounce and periodic spike generation for one switch
module spike_encoder_channel
    import snn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SPIKE_PERIOD    = DEFAULT_SPIKE_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic switch_raw,
    output logic switch_db,
    output logic spike
);
    localparam int CW = db_cnt_w(DEBOUNCE_CYCLES);
    localparam int PW = phase_w(SPIKE_PERIOD);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(SPIKE_PERIOD - 1);

    logic          s1, s2, flip, db_next;
    logic [CW-1:0] cnt;
    logic [PW-1:0] phase;

    always_comb begin
        flip    = (s2 != switch_db) && (cnt == CNT_LAST);
        db_next = switch_db ^ flip;
    end

    // the rate generator runs only while db is high both before and after this edge,
    // so a falling db suppresses a spike that would land on the wrap edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            cnt       <= '0;
            switch_db <= 1'b0;
            phase     <= '0;
            spike     <= 1'b0;
        end else begin
            s1        <= switch_raw;
            s2        <= s1;
            cnt       <= (s2 == switch_db || flip) ? '0 : cnt + 1'b1;
            switch_db <= db_next;
            if (!(switch_db && db_next)) begin
                phase <= '0;
                spike <= 1'b0;
            end else if (!enable) begin
                spike <= 1'b0;
            end else begin
                spike <= (phase == PH_LAST);
                phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
            end
        end
    end
endmodule

// File: rtl/switch_spike_encoder.sv
// switch_spike_encoder: two independent switch-to-spike channels feeding the XOR SNN core
module switch_spike_encoder
    import snn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SPIKE_PERIOD    = DEFAULT_SPIKE_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic switch_raw_0,
    input  logic switch_raw_1,
    output logic switch_db_0,
    output logic switch_db_1,
    output logic spike_out_0,
    output logic spike_out_1
);
    initial begin
        if (DEBOUNCE_CYCLES < 1) $fatal(1, "DEBOUNCE_CYCLES must be >= 1");
        if (SPIKE_PERIOD < 2) $fatal(1, "SPIKE_PERIOD must be >= 2");
    end

    spike_encoder_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SPIKE_PERIOD(SPIKE_PERIOD)) u_ch0 (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .switch_raw(switch_raw_0), .switch_db(switch_db_0), .spike(spike_out_0)
    );

    spike_encoder_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SPIKE_PERIOD(SPIKE_PERIOD)) u_ch1 (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .switch_raw(switch_raw_1), .switch_db(switch_db_1), .spike(spike_out_1)
    );
endmodule
